// File: rtl/ram_pkg.sv
// Shared constants and word type for the 64x8 scratch RAM.
package ram_pkg;
   localparam int RAM_DATA_WIDTH = 8;
   localparam int RAM_ADDR_WIDTH = 6;
   localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

   typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;
endpackage

// File: rtl/ram_64x8.sv
// 64x8 single-port flop-based RAM with registered, write-first read and async clear.
module ram_64x8
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] ram_address,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [DATA_WIDTH-1:0] data_out_d;

   // Write-first: a write to the read address forwards the incoming byte.
   always_comb begin
      data_out_d = mem_q[ram_address];
      if (write_enable) begin
         data_out_d = data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         data_out_q <= '0;
      end else begin
         if (write_enable) begin
            mem_q[ram_address] <= data_in;
         end
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_64x8.sv
// Directed self-checking bench for ram_64x8.
module tb_ram_64x8;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic [5:0] ram_address;
   logic       write_enable;
   logic [7:0] data_out;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_mem [64];

   ram_64x8 dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .ram_address  (ram_address),
      .write_enable (write_enable),
      .data_out     (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Apply one operation, clock it, return #1 after the edge.
   task automatic op(input logic we, input logic [5:0] addr, input logic [7:0] din);
      write_enable = we;
      ram_address  = addr;
      data_in      = din;
      @(posedge clk);
      #1;
      if (we && !rst) exp_mem[addr] = din;
   endtask

   task automatic wr(input logic [5:0] addr, input logic [7:0] din);
      op(1'b1, addr, din);
   endtask

   task automatic rd(input logic [5:0] addr);
      op(1'b0, addr, 8'h00);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 64; i++) exp_mem[i] = 8'h00;
   endtask

   initial begin
      rst          = 1'b1;
      data_in      = 8'h00;
      ram_address  = 6'd0;
      write_enable = 1'b0;
      clear_model();

      // Reset with the clock running; a write attempt during reset is ignored.
      op(1'b1, 6'd3, 8'h77);
      op(1'b0, 6'd0, 8'h00);
      chk("reset_dout", data_out, 8'h00);
      rst = 1'b0;

      rd(6'd0);  chk("rst_rd0",  data_out, 8'h00);
      rd(6'd2);  chk("rst_rd2",  data_out, 8'h00);
      rd(6'd7);  chk("rst_rd7",  data_out, 8'h00);
      rd(6'd63); chk("rst_rd63", data_out, 8'h00);
      rd(6'd3);  chk("rst_wr_ignored", data_out, 8'h00);

      // Basic write then read back.
      wr(6'd0, 8'h10); chk("wr0_fwd", data_out, 8'h10);
      wr(6'd2, 8'h11); chk("wr2_fwd", data_out, 8'h11);
      wr(6'd7, 8'hAF); chk("wr7_fwd", data_out, 8'hAF);
      rd(6'd0); chk("rd0", data_out, 8'h10);
      rd(6'd2); chk("rd2", data_out, 8'h11);
      rd(6'd7); chk("rd7", data_out, 8'hAF);

      // data_out must not follow the address between edges.
      ram_address = 6'd0;
      #2;
      chk("no_comb_path", data_out, 8'hAF);

      // Read-during-write, write-first.
      wr(6'd5, 8'h3C);
      rd(6'd5); chk("rd5_old", data_out, 8'h3C);
      wr(6'd5, 8'h5A); chk("rdw_first", data_out, 8'h5A);
      rd(6'd5); chk("rd5_new", data_out, 8'h5A);

      // Boundary addresses and neighbours.
      wr(6'd63, 8'hFF);
      wr(6'd0,  8'h01);
      rd(6'd63); chk("rd63", data_out, 8'hFF);
      rd(6'd0);  chk("rd0_b", data_out, 8'h01);
      rd(6'd62); chk("rd62", data_out, 8'h00);
      rd(6'd1);  chk("rd1",  data_out, 8'h00);

      // Asynchronous reset mid-operation.
      wr(6'd7, 8'hAF); chk("pre_rst_dout", data_out, 8'hAF);
      write_enable = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_dout", data_out, 8'h00);
      clear_model();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd(6'd7);  chk("post_rst_rd7",  data_out, 8'h00);
      rd(6'd63); chk("post_rst_rd63", data_out, 8'h00);
      rd(6'd5);  chk("post_rst_rd5",  data_out, 8'h00);

      // No-write isolation: fill a pattern, then sweep with data_in=0xEE and we=0.
      for (int i = 0; i < 64; i++) wr(6'(i), 8'(i) ^ 8'hA5);
      for (int i = 0; i < 64; i++) begin
         op(1'b0, 6'(i), 8'hEE);
         chk($sformatf("iso_rd%0d", i), data_out, exp_mem[i]);
      end
      for (int i = 0; i < 64; i += 9) begin
         op(1'b0, 6'(i), 8'hEE);
         chk($sformatf("iso_again%0d", i), data_out, 8'(i) ^ 8'hA5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_64x8.md
# ram_64x8

Single-port 64-word × 8-bit synchronous RAM with a registered read port, a synchronous write port and an asynchronous clear. It is a small scratch storage element: a host drives an address, data and a write strobe each cycle and reads back stored bytes one cycle later. All storage is built from flip-flops so that reset can clear the array.

## Interface

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 6: address width; depth = 2**ADDR_WIDTH = 64 words.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge except reset.
- rst, input, 1: reset, asynchronous, active-high.
- data_in, input, DATA_WIDTH: write data.
- ram_address, input, ADDR_WIDTH: word address for both read and write.
- write_enable, input, 1: 1 = write data_in to ram_address on this edge; 0 = read only.
- data_out, output, DATA_WIDTH: registered read data.

## Operation

- Storage: array mem[0..63] of DATA_WIDTH bits.
- Write: on a rising clk with write_enable=1 and rst=0, mem[ram_address] <= data_in. No other location changes.
- Read: on every rising clk with rst=0, data_out <= the word at ram_address, regardless of write_enable.
- Read-during-write (same edge, same address, write_enable=1) is write-first: data_out takes the new data_in value, not the old contents.
- The address is fully decoded; all 64 locations are valid, no out-of-range case exists.
- Reset: while rst=1, every mem location = 0x00 and data_out = 0x00, immediately (no clock needed). Writes are ignored during reset.
- Reset released mid-operation: first rising edge with rst=0 resumes normal operation; all previous contents are lost.
- X/unknown on write_enable is not a supported condition; the bench must drive it to 0 or 1.

## Timing

- Write latency: data is stored at the rising edge where write_enable=1. It can be read with a read sampled at the next edge.
- Read latency: 1 cycle. ram_address is sampled at edge N, and data_out is valid after edge N and holds until edge N+1.
- data_out changes only on rising clk or on rst assertion; it never follows ram_address combinationally.
- Back-to-back operations at consecutive addresses are allowed every cycle with no bubbles.
- Reset value of data_out is 0x00.
- Asserting rst takes effect asynchronously. Deassertion is expected synchronous to clk at the system level; no internal synchronizer is provided.

## Structure

- Shared package ram_pkg holds:
  - the default constants RAM_DATA_WIDTH = 8 and RAM_ADDR_WIDTH = 6;
  - the derived RAM_DEPTH = 64;
  - the word typedef ram_word_t (logic [7:0]).
- Single flat module ram_64x8. No sub-module is warranted.
- The array is implemented as a register array with an asynchronous clear. It is intentionally not inferred as a block RAM.
- The write-address decode and the read mux are written as plain indexed accesses.

## Test plan

- Reset: assert rst with clk running, then release. data_out = 0x00, and reading addresses 0, 2, 7 and 63 each returns 0x00.
- Basic write/read: with write_enable=1, write 0x10@0, 0x11@2 and 0xAF@7 on consecutive edges. Then with write_enable=0, read 0, 2, 7. data_out = 0x10, 0x11, 0xAF, each one cycle after its address is sampled.
- Read-during-write: location 5 holds 0x3C. Write 0x5A@5 with write_enable=1. data_out after that edge = 0x5A (write-first), and a subsequent read@5 also returns 0x5A.
- Boundary addresses: write 0xFF@63 and 0x01@0. Read 63 then 0. Results are 0xFF and 0x01, and neighbours 62 and 1 are unchanged (0x00).
- Reset mid-operation: after writing 0xAF@7, assert rst asynchronously between edges. data_out goes to 0x00 immediately. After release, read@7 returns 0x00.
- No-write isolation: with write_enable=0, drive data_in=0xEE across all 64 addresses. Every read returns its prior contents, and no location becomes 0xEE.
